// File: rtl/rx_timer_pkg.sv
// Shared types and default constants for the USB receive bit timer.
package rx_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int CLKS_PER_BIT_DEF  = 8;
    localparam int SAMPLE_PHASE_DEF  = 3;
    localparam int BITS_PER_BYTE_DEF = 8;

    // Consecutive ones after which the next received bit is a stuff bit.
    localparam int STUFF_LIMIT = 6;

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear, synchronous load and a
// programmable rollover value. The rollover flag is high in the cycle whose
// count_enable makes the counter wrap to zero.
module flex_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count_out,
    output logic             rollover_flag
);

    logic at_rollover;

    assign at_rollover   = (count_out == rollover_val);
    assign rollover_flag = count_enable && !clear && !load && at_rollover;

    // Count register: clear beats load, load beats counting.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so this block cannot race other clocked logic.
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (load) begin
            count_out <= load_val;
        end else if (count_enable) begin
            count_out <= at_rollover ? '0 : count_out + WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_bit_timer.sv
// USB receive bit timer: per-bit phase counter resynchronised by d_edge,
// mid-bit shift_enable strobe and byte completion pulse.
// Optional bit-stuff removal/checking is built when RX_BIT_STUFF_EN is defined.
module rx_bit_timer
    import rx_timer_pkg::*;
#(
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,   // must be at least 4
    parameter int SAMPLE_PHASE  = SAMPLE_PHASE_DEF,
    parameter int BITS_PER_BYTE = BITS_PER_BYTE_DEF
) (
    input  logic                             clk,
    input  logic                             n_rst,
    input  logic                             enable_timer,
    input  logic                             d_edge,
    input  logic                             d_orig,
    output logic                             shift_enable,
    output logic                             byte_received,
    output logic [$clog2(BITS_PER_BYTE):0]   bit_count,
    output logic                             stuff_error
);

    localparam int PHASE_W = $clog2(CLKS_PER_BIT);
    localparam int COUNT_W = $clog2(BITS_PER_BYTE) + 1;

    localparam logic [PHASE_W-1:0] SAMPLE_VAL = PHASE_W'(SAMPLE_PHASE);
    localparam logic [PHASE_W-1:0] PHASE_TOP  = PHASE_W'(CLKS_PER_BIT - 1);
    localparam logic [COUNT_W-1:0] COUNT_TOP  = COUNT_W'(BITS_PER_BYTE - 1);

    state_t             state;
    logic [PHASE_W-1:0] phase;
    logic               run;
    logic               clear_cnt;
    logic               sample_point;
    logic               stuff_bit;
    logic               byte_done;
    logic               phase_wrap_unused;

    assign run          = (state == RUN);
    // Counters are cleared while idle and on the edge that leaves RUN.
    assign clear_cnt    = !run || !enable_timer;
    assign sample_point = run && (phase == SAMPLE_VAL);
    // Decoded straight from registered state so the strobe lines up with the
    // sample phase even when a resync edge arrives in the same cycle.
    assign shift_enable = sample_point && !stuff_bit;

    // Phase within the current bit; a d_edge marks phase 0, so load 1.
    flex_counter #(
        .WIDTH(PHASE_W)
    ) u_phase_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear_cnt),
        .load         (run && d_edge),
        .load_val     (PHASE_W'(1)),
        .count_enable (run),
        .rollover_val (PHASE_TOP),
        .count_out    (phase),
        .rollover_flag(phase_wrap_unused)
    );

    // Bits shifted into the current byte; wraps to 0 as the byte completes.
    flex_counter #(
        .WIDTH(COUNT_W)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear_cnt),
        .load         (1'b0),
        .load_val     ('0),
        .count_enable (shift_enable),
        .rollover_val (COUNT_TOP),
        .count_out    (bit_count),
        .rollover_flag(byte_done)
    );

`ifdef RX_BIT_STUFF_EN
    logic [2:0] ones_cnt;

    assign stuff_bit = (ones_cnt == 3'(STUFF_LIMIT));
`else
    logic unused_d_orig;

    assign stuff_bit     = 1'b0;
    assign stuff_error   = 1'b0;
    assign unused_d_orig = d_orig;
`endif

    // Control FSM with its registered pulse outputs and stuff tracking.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            byte_received <= 1'b0;
`ifdef RX_BIT_STUFF_EN
            ones_cnt      <= '0;
            stuff_error   <= 1'b0;
`endif
        end else begin
            // byte_done is already masked when the timer is being disabled.
            byte_received <= byte_done;

            case (state)
                IDLE:    if (enable_timer)  state <= RUN;
                RUN:     if (!enable_timer) state <= IDLE;
                default: state <= IDLE;
            endcase

`ifdef RX_BIT_STUFF_EN
            stuff_error <= 1'b0;
            if (clear_cnt) begin
                ones_cnt <= '0;
            end else if (sample_point) begin
                if (stuff_bit) begin
                    // Stuff bit is discarded; a one here breaks the rule.
                    ones_cnt    <= '0;
                    stuff_error <= d_orig;
                end else if (d_orig) begin
                    ones_cnt <= ones_cnt + 3'd1;
                end else begin
                    ones_cnt <= '0;
                end
            end
`endif
        end
    end

endmodule
